// File: rtl/pdm_pkg.sv
// pdm_pkg: shared widths, modulator state type and accumulator saturation
package pdm_pkg;
   localparam int PDM_DATA_W  = 16;
   localparam int PDM_ACC_W   = 22;
   localparam int PDM_OSR     = 64;
   localparam int PDM_CLK_DIV = 1;
   typedef enum logic [1:0] {IDLE, PRIME, RUN} pdm_state_e;
   function automatic logic signed [63:0] sat_acc(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction
endpackage

// File: rtl/sd2_core.sv
// sd2_core: 2nd-order sigma-delta integrators with saturation and 1-bit quantiser
module sd2_core
   import pdm_pkg::*;
#(
   parameter int DATA_W = PDM_DATA_W,
   parameter int ACC_W  = PDM_ACC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    step,
   input  logic                    clr,
   input  logic                    fb,
   input  logic signed [ACC_W-1:0] xs,
   output logic                    bit_o
);
   localparam logic signed [63:0] FS = 64'sd1 <<< (DATA_W - 1);
   logic signed [63:0]      fbv;
   logic signed [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d, i1_n, i2_n;
   // one modulator step: both integrators subtract the fed-back full-scale level
   always_comb begin
      fbv   = fb ? FS : -FS;
      i1_n  = ACC_W'(sat_acc(64'(i1_q) + 64'(xs) - fbv, ACC_W));
      i2_n  = ACC_W'(sat_acc(64'(i2_q) + 64'(i1_n) - fbv, ACC_W));
      bit_o = ~i2_n[ACC_W-1];
      i1_d  = clr ? '0 : (step ? i1_n : i1_q);
      i2_d  = clr ? '0 : (step ? i2_n : i2_q);
   end
   // integrator state
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         i1_q <= '0;
         i2_q <= '0;
      end else begin
         i1_q <= i1_d;
         i2_q <= i2_d;
      end
endmodule

// File: rtl/pdm_sigma_delta_tx.sv
// pdm_sigma_delta_tx: PCM-to-PDM transmitter with bit-clock divider, 1-entry holding register and run/idle control
module pdm_sigma_delta_tx
   import pdm_pkg::*;
#(
   parameter int DATA_W  = PDM_DATA_W,
   parameter int OSR     = PDM_OSR,
   parameter int CLK_DIV = PDM_CLK_DIV,
   parameter int ACC_W   = PDM_ACC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              pdm_out,
   output logic              pdm_strobe,
   output logic              frame_start,
   output logic              underrun,
   input  logic              clr_underrun
);
   localparam int OSR_W = $clog2(OSR);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   pdm_state_e               state_q, state_d;
   logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
   logic [OSR_W-1:0]         osr_cnt_q, osr_cnt_d;
   logic                     hold_v_q, hold_v_d;
   logic [DATA_W-1:0]        hold_data_q, hold_data_d;
   logic signed [DATA_W-1:0] cur_x_q, cur_x_d;
   logic                     pdm_out_q, pdm_out_d, strobe_q, strobe_d, fs_q, fs_d, underrun_q, underrun_d;
   logic                     tick, boundary, accept, load, step, clr, core_bit;
   logic signed [ACC_W-1:0]  x_ext, xs;
   assign s_ready     = en && (state_q != IDLE) && !hold_v_q;
   assign pdm_out     = pdm_out_q;
   assign pdm_strobe  = strobe_q;
   assign frame_start = fs_q;
   assign underrun    = underrun_q;
   assign x_ext       = ACC_W'(cur_x_d);
   assign xs          = x_ext - (x_ext >>> 2);
   assign pdm_out_d   = step ? core_bit : (tick ? ~pdm_out_q : pdm_out_q);
   // dividers, holding register and state sequencing; a loaded sample is modulated on the same strobe
   always_comb begin
      tick        = div_cnt_q == DIV_W'(CLK_DIV - 1);
      boundary    = osr_cnt_q == OSR_W'(OSR - 1);
      accept      = s_valid && s_ready;
      div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
      state_d     = state_q;
      osr_cnt_d   = osr_cnt_q;
      load        = 1'b0;
      step        = 1'b0;
      fs_d        = 1'b0;
      strobe_d    = tick;
      underrun_d  = underrun_q && !clr_underrun;
      clr         = !en || (state_q == IDLE);
      if (!en) begin
         state_d   = IDLE;
         osr_cnt_d = '0;
      end else if (state_q == IDLE) begin
         state_d = PRIME;
      end else if (tick && (state_q == RUN || hold_v_q)) begin
         step      = 1'b1;
         state_d   = RUN;
         osr_cnt_d = (state_q == RUN) ? osr_cnt_q + 1'b1 : '0;
         if (state_q == PRIME || boundary) begin
            load = hold_v_q;
            fs_d = 1'b1;
            if (!hold_v_q) underrun_d = 1'b1;
         end
      end
      cur_x_d     = !en ? '0 : (load ? hold_data_q : cur_x_q);
      hold_v_d    = en && (accept || (hold_v_q && !load));
      hold_data_d = accept ? s_data : hold_data_q;
   end
   // state registers
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q     <= IDLE;
         div_cnt_q   <= '0;
         osr_cnt_q   <= '0;
         hold_v_q    <= 1'b0;
         hold_data_q <= '0;
         cur_x_q     <= '0;
         pdm_out_q   <= 1'b0;
         strobe_q    <= 1'b0;
         fs_q        <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         osr_cnt_q   <= osr_cnt_d;
         hold_v_q    <= hold_v_d;
         hold_data_q <= hold_data_d;
         cur_x_q     <= cur_x_d;
         pdm_out_q   <= pdm_out_d;
         strobe_q    <= strobe_d;
         fs_q        <= fs_d;
         underrun_q  <= underrun_d;
      end
   sd2_core #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_core (
      .clk   (clk),
      .rst   (rst),
      .step  (step),
      .clr   (clr),
      .fb    (pdm_out_q),
      .xs    (xs),
      .bit_o (core_bit)
   );
endmodule

// File: tb/tb_pdm_sigma_delta_tx.sv
// tb_pdm_sigma_delta_tx: directed checks of reset, idle pattern, DC density, backpressure and underrun
module tb_pdm_sigma_delta_tx;
   logic        clk = 0, rst = 1, en = 0, s_valid = 0, clr_underrun = 0;
   logic [15:0] s_data = '0;
   logic        s_ready, pdm_out, pdm_strobe, frame_start, underrun;
   int          n_tests = 0, n_fail = 0, bits = 0, ones = 0, flips = 0, bad_chg = 0, rdy_cnt = 0, xfers = 0;
   logic        prev_out = 0, src_on = 0, src_seq = 0;
   logic [15:0] src_val = '0;

   always #5 clk = ~clk;

   pdm_sigma_delta_tx #(.CLK_DIV(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .pdm_out      (pdm_out),
      .pdm_strobe   (pdm_strobe),
      .frame_start  (frame_start),
      .underrun     (underrun),
      .clr_underrun (clr_underrun)
   );

   task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
      n_tests++;
      if (obs > exp + tol || obs < exp - tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, obs, exp, tol);
      end
   endtask

   task automatic cyc();
      if (pdm_strobe) begin
         bits++;
         ones += int'(pdm_out);
         if (pdm_out != prev_out) flips++;
      end else if (pdm_out != prev_out) bad_chg++;
      prev_out = pdm_out;
      if (s_ready) rdy_cnt++;
      s_valid = src_on;
      s_data  = src_val;
      #1;
      if (s_valid && s_ready) begin
         xfers++;
         if (src_seq) src_val = src_val + 16'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fs(input string tag);
      int n = 0;
      cyc();
      while (!frame_start && n < 1000) begin
         cyc();
         n++;
      end
      check({tag, "_frame_start"}, frame_start, 1);
   endtask

   task automatic run_bits(input int n);
      bits = 0;
      ones = 0;
      for (int k = 0; k < 4 * n && bits < n; k++) cyc();
   endtask

   task automatic idle_chk(input string tag);
      en = 0;
      cyc();
      bits  = 0;
      flips = 0;
      repeat (8) cyc();
      check({tag, "_idle_strobes"}, bits, 4);
      check({tag, "_idle_toggles"}, flips, 4);
   endtask

   task automatic dc_test(input string tag, input logic [15:0] val, input int n, input int exp, input int tol);
      idle_chk(tag);
      src_seq = 0;
      src_val = val;
      src_on  = 1;
      en      = 1;
      wait_fs(tag);
      run_bits(n);
      check({tag, "_ones"}, ones, exp, tol);
      check({tag, "_underrun"}, underrun, 0);
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_pdm_out"}, pdm_out, 0);
      check({tag, "_pdm_strobe"}, pdm_strobe, 0);
      check({tag, "_frame_start"}, frame_start, 0);
      check({tag, "_underrun"}, underrun, 0);
      check({tag, "_s_ready"}, s_ready, 0);
   endtask

   initial begin
      #2 rst = 0;
      #1 chk_zero("reset");
      @(negedge clk) rst = 1;
      @(posedge clk) #1;
      idle_chk("post_reset");
      dc_test("dc_zero", 16'd0, 1024, 512, 2);
      dc_test("dc_half", 16'd16384, 1024, 704, 4);
      dc_test("dc_negfs", 16'h8000, 1024, 128, 10);
      idle_chk("seq");
      src_seq = 1;
      src_val = 16'd100;
      src_on  = 1;
      xfers   = 0;
      rdy_cnt = 0;
      en      = 1;
      wait_fs("seq0");
      check("seq0_x", dut.cur_x_q, 100);
      for (int f = 1; f <= 4; f++) begin
         wait_fs("seq");
         check("seq_x", dut.cur_x_q, 100 + f);
      end
      check("seq_transfers", xfers, 5);
      check("seq_ready_cycles", rdy_cnt, 5);
      src_on = 0;
      wait_fs("und");
      check("und_set", underrun, 1);
      check("und_repeat_x", dut.cur_x_q, 104);
      src_on = 1;
      wait_fs("und2");
      check("und_refill_x", dut.cur_x_q, 105);
      check("und_sticky", underrun, 1);
      src_on = 0;
      clr_underrun = 1;
      repeat (4) cyc();
      check("und_clr", underrun, 0);
      wait_fs("und3");
      check("und_clr_race", underrun, 1);
      check("und3_repeat_x", dut.cur_x_q, 105);
      clr_underrun = 0;
      cyc();
      check("und_hold", underrun, 1);
      src_on = 1;
      repeat (20) cyc();
      #2 rst = 0;
      #1 chk_zero("midrun_reset");
      en = 0;
      @(negedge clk) rst = 1;
      @(posedge clk) #1;
      prev_out = pdm_out;
      idle_chk("after_reset");
      dc_test("restart", 16'd0, 256, 128, 2);
      check("no_offstrobe_change", bad_chg, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
